// File: rtl/cordic_result_fifo_if.sv
// Handshake bundle between the CORDIC result FIFO and the producer/consumer side.
// The master drives push/pop/clear; the slave (FIFO) drives data and status.
interface cordic_result_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  clear;
  logic                  valid_out_interface;
  logic [DATA_WIDTH-1:0] out_interface;
  logic                  read_fifo_en;
  logic [DATA_WIDTH-1:0] out_fifo;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;

  modport master (
    output clear, valid_out_interface, out_interface, read_fifo_en,
    input  out_fifo, empty, full, level, overflow
  );

  modport slave (
    input  clear, valid_out_interface, out_interface, read_fifo_en,
    output out_fifo, empty, full, level, overflow
  );
endinterface

// File: rtl/cordic_result_fifo.sv
// Circular FWFT buffer for CORDIC results feeding the AHB-Lite slave.
// Extra pointer MSB distinguishes full from empty; overflow is sticky until clear/reset.
module cordic_result_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input logic                    HCLK,
  input logic                    HRESETn,
  cordic_result_fifo_if.slave    bus
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  overflow_q;

  logic empty_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  // Status decode from registered pointers only
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // A pop frees a slot in the same edge, so a push into a full FIFO is allowed alongside it
  assign pop_c  = bus.read_fifo_en & ~empty_c;
  assign push_c = bus.valid_out_interface & (~full_c | pop_c);
  assign drop_c = bus.valid_out_interface & full_c & ~pop_c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop_c) overflow_q <= 1'b1;
    end
  end

  // Storage is not reset; validity is tracked by the pointers
  always_ff @(posedge HCLK) begin
    if (push_c && !bus.clear) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.out_interface;
  end

  assign bus.out_fifo = empty_c ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign bus.empty    = empty_c;
  assign bus.full     = full_c;
  assign bus.level    = wr_ptr - rd_ptr;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/cordic_result_fifo.md
Name: cordic_result_fifo

Overview:
- Result buffer between the CORDIC core output and the AHB-Lite CORDIC bus slave.
- Captures each 32-bit CORDIC result on its output-valid strobe and stores it in a DEPTH-entry circular FIFO.
- Presents the oldest entry first-word-fall-through to the bus slave, which pops it with a single-cycle read enable.
- Reports empty/full/level status and a sticky overflow flag for firmware diagnostics.

Parameters:
DATA_WIDTH, 32, width of one CORDIC result word
DEPTH, 8, number of entries; must be a power of two, at least 2
ADDR_WIDTH, 3, log2(DEPTH); pointer index width

Ports:
HCLK  input  1  single clock, rising edge
HRESETn  input  1  asynchronous active-low reset
clear  input  1  synchronous flush: pointers, level and overflow return to reset values
valid_out_interface  input  1  CORDIC result valid; one push per high cycle
out_interface  input  DATA_WIDTH  CORDIC result word, sampled when valid_out_interface=1
read_fifo_en  input  1  pop strobe from bus slave; one pop per high cycle
out_fifo  output  DATA_WIDTH  oldest stored word (FWFT); 0 when empty
empty  output  1  1 when level==0
full  output  1  1 when level==DEPTH
level  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH
overflow  output  1  sticky; set when a push is dropped because the FIFO is full

Behaviour:
- Reset: one clock HCLK; reset is asynchronous and active-low (HRESETn).
  - HRESETn low, independent of HCLK: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, overflow=0, out_fifo=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data immediately.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory.
  - Pointers wrap naturally mod 2*DEPTH.
  - empty = (wr_ptr==rd_ptr).
  - full = index bits equal and MSBs differ.
  - level = wr_ptr - rd_ptr, computed modulo 2^(ADDR_WIDTH+1).
- Push condition: valid_out_interface & (~full | pop). The word is written at mem[wr_ptr] and wr_ptr increments on that HCLK edge.
- Pop condition: read_fifo_en & ~empty. rd_ptr increments on that edge.
  - read_fifo_en while empty is ignored; no flag, no pointer change.
- Output: out_fifo = mem[rd_ptr[ADDR_WIDTH-1:0]] combinationally when ~empty, else 0.
  - Read latency is zero: a word pushed at edge N is visible on out_fifo after edge N.
- Simultaneous events:
  - Push and pop while full: both occur, level stays DEPTH, full stays 1, no overflow.
  - Push and pop while empty: only the push occurs, and level becomes 1 after the edge.
  - Push and pop otherwise: both occur and level is unchanged.
  - Push while full without pop: the word is dropped, pointers are unchanged, and overflow goes to 1 on that edge.
- Overflow flag: stays 1 until clear or reset. clear takes priority over a simultaneous drop.
- clear: takes priority over push and pop in the same cycle.
  - After the edge: pointers=0, level=0, empty=1, full=0, overflow=0.
  - A push presented in the clear cycle is discarded.
- All status outputs (empty, full, level) are derived from registered pointers; no combinational path from inputs to status.
- Only out_fifo depends combinationally on state; there is no combinational path from any input to any output.

Test Plan:
- Reset then idle: HRESETn=0 for 2 cycles, release -> empty=1, full=0, level=0, overflow=0, out_fifo=0; read_fifo_en=1 for 3 cycles changes nothing.
- Fill and drain: push 0x00000001..0x00000008 on consecutive cycles -> full=1, level=8 after 8th edge. Pop 8 times -> out_fifo sequence 1..8, then empty=1, out_fifo=0.
- Overflow: with FIFO full, push 0xDEADBEEF without pop -> level stays 8, overflow=1. Drain shows 1..8 with no 0xDEADBEEF. overflow stays 1 until clear=1 for one cycle, then 0.
- Simultaneous at boundaries:
  - Full: push 0xA5A5A5A5 with pop -> out_fifo advances 1->2, level=8, overflow=0; 0xA5A5A5A5 appears as the 8th word on drain.
  - Empty: push 0x12345678 with pop -> level=1, out_fifo=0x12345678.
- Wrap-around: 20 push/pop pairs interleaved at level 3 with DEPTH=8 -> strict FIFO order, level constant 3, full/empty never asserted.
- Async reset mid-operation: level=5, assert HRESETn low between clock edges -> empty=1, level=0, out_fifo=0 before the next HCLK edge. After release, first push 0x0000CAFE is read back as out_fifo=0x0000CAFE.
